// File: rtl/bus_pkg.sv
// Shared definitions for the bus generator/arbiter: ID width, broadcast code, lane FSM states.
package bus_pkg;

    localparam int unsigned ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    typedef enum logic [1:0] {
        ARB,
        POP,
        PUSH
    } lane_state_e;

endpackage

// File: rtl/bus_lane.sv
// One bus lane: round-robin arbitration over source FIFOs, pop, then push to the destination(s).
module bus_lane
    import bus_pkg::*;
#(
    parameter int unsigned      drvrs     = 4,
    parameter int unsigned      pckg_sz   = 16,
    parameter logic [ID_W-1:0]  broadcast = BROADCAST
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [drvrs-1:0]                i_pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   i_d_pop,
    output logic [drvrs-1:0]                o_pop,
    output logic [drvrs-1:0]                o_push,
    output logic [pckg_sz-1:0]              o_d_push
);

    localparam int unsigned SW = (drvrs > 1) ? $clog2(drvrs) : 1;

    lane_state_e        r_state;
    lane_state_e        w_state_nxt;
    logic [SW-1:0]      r_ptr;
    logic [SW-1:0]      r_src;
    logic [pckg_sz-1:0] r_data;
    logic [SW-1:0]      w_grant;
    logic               w_found;
    logic [SW-1:0]      w_ptr_nxt;
    logic [SW-1:0]      w_idx;
    logic [ID_W-1:0]    w_id;

    assign w_id     = r_data[pckg_sz-1 -: ID_W];
    assign o_d_push = r_data;

    // First pending source at or after the pointer, wrapping modulo drvrs.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            w_idx = SW'((32'(r_ptr) + i) % drvrs);
            if (!w_found && i_pndng[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_ptr_nxt = SW'((32'(r_src) + 32'd1) % drvrs);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB:     w_state_nxt = w_found ? POP : ARB;
            POP:     w_state_nxt = PUSH;
            PUSH:    w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src  <= '0;
            r_ptr  <= '0;
            r_data <= '0;
        end else begin
            if (r_state == ARB && w_found) begin
                r_src <= w_grant;
            end
            if (r_state == POP) begin
                r_data <= i_d_pop[r_src];
            end
            if (r_state == PUSH) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // IDs at or above drvrs match no agent, so the packet is silently dropped.
    always_comb begin
        o_pop  = '0;
        o_push = '0;
        for (int unsigned k = 0; k < drvrs; k++) begin
            if (r_state == POP) begin
                o_pop[k] = (32'(r_src) == k);
            end
            if (r_state == PUSH) begin
                if (w_id == broadcast) begin
                    o_push[k] = (32'(r_src) != k);
                end else begin
                    o_push[k] = (32'(w_id) == k);
                end
            end
        end
    end

endmodule

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus generator and arbiter: one independent bus_lane per lane, fanning the lane word out.
module bus_gnrtr_n_rbtr
    import bus_pkg::*;
#(
    parameter int unsigned      bits      = 1,
    parameter int unsigned      drvrs     = 4,
    parameter int unsigned      pckg_sz   = 16,
    parameter logic [ID_W-1:0]  broadcast = BROADCAST
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    for (genvar g = 0; g < bits; g++) begin : g_lane
        logic [pckg_sz-1:0] w_bus;

        bus_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .i_clk    (clk),
            .i_rst_n  (reset),
            .i_pndng  (pndng[g]),
            .i_d_pop  (D_pop[g]),
            .o_pop    (pop[g]),
            .o_push   (push[g]),
            .o_d_push (w_bus)
        );

        for (genvar k = 0; k < drvrs; k++) begin : g_fanout
            assign D_push[g][k] = w_bus;
        end
    end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Scoreboard bench: FIFO models feed the lane, a negedge monitor checks every pop/push event.
module tb_bus_gnrtr_n_rbtr;
    import bus_pkg::*;

    localparam int unsigned BITS  = 1;
    localparam int unsigned DRVRS = 4;
    localparam int unsigned PW    = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [BITS-1:0][DRVRS-1:0]         pndng;
    logic [BITS-1:0][DRVRS-1:0][PW-1:0] D_pop;
    logic [BITS-1:0][DRVRS-1:0]         pop;
    logic [BITS-1:0][DRVRS-1:0]         push;
    logic [BITS-1:0][DRVRS-1:0][PW-1:0] D_push;

    bus_gnrtr_n_rbtr #(
        .bits      (BITS),
        .drvrs     (DRVRS),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_push;
        logic [3:0] vec;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] src_q[DRVRS][$];
    logic [3:0]  drv_taken;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_pop_cyc = -100;
    int          pop_cycs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    task automatic exp_ev(input bit p, input logic [3:0] v, input logic [15:0] d);
        exp_q.push_back('{is_push: p, vec: v, data: d});
    endtask

    task automatic send(input int a, input logic [15:0] w);
        src_q[a].push_back(w);
    endtask

    function automatic bit fifos_busy();
        bit busy = 1'b0;
        for (int k = 0; k < DRVRS; k++) if (src_q[k].size() != 0) busy = 1'b1;
        return busy;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifos_busy()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain timeout", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    // First-word fall-through FIFO models; a word leaves just after the edge that ends POP.
    initial begin
        pndng = '0;
        D_pop = '0;
        forever begin
            @(negedge clk);
            drv_taken = pop[0];
            @(posedge clk);
            #1;
            for (int k = 0; k < DRVRS; k++) begin
                if (drv_taken[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                pndng[0][k] = (src_q[k].size() != 0);
                D_pop[0][k] = (src_q[k].size() != 0) ? src_q[k][0] : 16'h0;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (pop[0] != '0) begin
                pop_cycs.push_back(cyc);
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected pop", 64'(pop[0]), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event kind at pop", 64'd0, 64'(mon_e.is_push));
                    check("pop vector", 64'(pop[0]), 64'(mon_e.vec));
                end
            end
            if (push[0] != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected push", 64'(push[0]), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event kind at push", 64'd1, 64'(mon_e.is_push));
                    check("push vector", 64'(push[0]), 64'(mon_e.vec));
                    check("pop to push latency", 64'(cyc - last_pop_cyc), 64'd1);
                    for (int k = 0; k < DRVRS; k++) begin
                        check($sformatf("D_push[0][%0d]", k), 64'(D_push[0][k]),
                              64'(mon_e.data));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int sz;
        repeat (3) @(negedge clk);
        check("reset pop", 64'(pop), 64'd0);
        check("reset push", 64'(push), 64'd0);
        check("reset D_push", 64'(D_push), 64'd0);
        reset = 1'b1;

        // Unicast from agent 1 to agent 2; pointer moves to 2.
        @(negedge clk);
        exp_ev(0, 4'b0010, 16'h0);
        exp_ev(1, 4'b0100, 16'h02AB);
        send(1, 16'h02AB);
        drain(30);

        // Reset during PUSH of an agent-3 packet: only its pop is ever observed.
        exp_ev(0, 4'b1000, 16'h0);
        send(3, 16'h0133);
        n = 0;
        while (!pop[0][3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait for pop[0][3]", 64'(n < 20), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async reset pop", 64'(pop), 64'd0);
        check("async reset push", 64'(push), 64'd0);
        check("async reset D_push", 64'(D_push), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Pointer restarted at 0: agent 1 wins before agent 2 (pointer 2 would pick agent 2).
        exp_ev(0, 4'b0010, 16'h0);
        exp_ev(1, 4'b0001, 16'h0011);
        exp_ev(0, 4'b0100, 16'h0);
        exp_ev(1, 4'b0001, 16'h0022);
        send(1, 16'h0011);
        send(2, 16'h0022);
        drain(40);

        // Broadcast from agent 3 reaches everyone except agent 3; pointer wraps to 0.
        exp_ev(0, 4'b1000, 16'h0);
        exp_ev(1, 4'b0111, 16'hFF5A);
        send(3, 16'hFF5A);
        drain(30);

        // Round-robin with all agents pending, agent 0 holding two packets.
        pop_cycs.delete();
        exp_ev(0, 4'b0001, 16'h0); exp_ev(1, 4'b0001, 16'h00A0);
        exp_ev(0, 4'b0010, 16'h0); exp_ev(1, 4'b0001, 16'h00A1);
        exp_ev(0, 4'b0100, 16'h0); exp_ev(1, 4'b0001, 16'h00A2);
        exp_ev(0, 4'b1000, 16'h0); exp_ev(1, 4'b0001, 16'h00A3);
        exp_ev(0, 4'b0001, 16'h0); exp_ev(1, 4'b0001, 16'h00A4);
        send(0, 16'h00A0);
        send(0, 16'h00A4);
        send(1, 16'h00A1);
        send(2, 16'h00A2);
        send(3, 16'h00A3);
        drain(60);
        check("round-robin pop count", 64'(pop_cycs.size()), 64'd5);
        for (int i = 1; i < 5; i++) begin
            if (pop_cycs.size() > i) begin
                check($sformatf("round-robin spacing %0d", i),
                      64'(pop_cycs[i] - pop_cycs[i-1]), 64'd3);
            end
        end

        // Invalid destination 0x09: pop only, packet dropped.
        exp_ev(0, 4'b0001, 16'h0);
        send(0, 16'h0911);
        drain(30);

        // Loopback from agent 2 to itself.
        exp_ev(0, 4'b0100, 16'h0);
        exp_ev(1, 4'b0100, 16'h0277);
        send(2, 16'h0277);
        drain(30);

        // Idle: no pending sources, no activity.
        sz = pop_cycs.size();
        repeat (20) @(negedge clk);
        check("idle pop activity", 64'(pop_cycs.size()), 64'(sz));
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
